stream_dense_layer: RTL and testbench

STREAM_DENSE_LAYER -- requirements
Module: stream_dense_layer

---
 rtl/stream_dense_layer.sv | 183 ++++++++++++++++++
 tb/tb_stream_dense_layer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_dense_layer.sv
// stream_dense_layer
//   Streaming fully-connected layer. Input activations arrive one beat per
//   handshake; each beat is multiplied by the matching weight row and the
//   product is added into one accumulator per neuron. After NUM_INPUTS beats
//   the bias is added and the sums are rescaled, saturated and activated
//   (ReLU or linear). Optionally the index of the largest output is found
//   with a sequential scan. The result is then held until the consumer
//   accepts it.
//
// Ports
//   clk, rst             sole clock (rising edge), synchronous active-high reset
//   in_valid/in_ready    input beat handshake; in_ready is high only while accumulating
//   in_data              signed Q(dataWidth-frac_bits).frac_bits activation
//   in_last              producer end-of-frame marker (checked only, never steers control)
//   w_addr               weight row index, equal to the beat counter
//   w_data               weight row for w_addr (asynchronous ROM), neuron j at [j*dataWidth +: dataWidth]
//   b_data               per-neuron biases, same packing
//   out_valid/out_ready  result handshake
//   out_data             activated outputs, same packing
//   out_class            index of the largest output (0 when ARGMAX_EN=0)
//   err_frame            one-cycle pulse when in_last disagrees with the beat count
module stream_dense_layer #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10,
  parameter int dataWidth   = 16,
  parameter int frac_bits   = 11,
  parameter int ACT_MODE    = 0,
  parameter int ARGMAX_EN   = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [dataWidth-1:0]               in_data,
  input  logic                               in_last,
  output logic [$clog2(NUM_INPUTS)-1:0]      w_addr,
  input  logic [NUM_NEURONS*dataWidth-1:0]   w_data,
  input  logic [NUM_NEURONS*dataWidth-1:0]   b_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_NEURONS*dataWidth-1:0]   out_data,
  output logic [$clog2(NUM_NEURONS)-1:0]     out_class,
  output logic                               err_frame
);

  localparam int AW    = $clog2(NUM_INPUTS);
  localparam int CW    = $clog2(NUM_NEURONS);
  localparam int PW    = 2 * dataWidth;
  localparam int ACC_W = PW + AW;
  // One extra bit so the bias addition can never wrap.
  localparam int SW    = ACC_W + 1;

  localparam logic [AW-1:0] LAST_BEAT   = AW'(NUM_INPUTS - 1);
  localparam logic [CW-1:0] LAST_NEURON = CW'(NUM_NEURONS - 1);

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};

  typedef enum logic [1:0] {
    S_ACC,
    S_ACT,
    S_ARG,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]               cnt;
  logic signed [ACC_W-1:0]     acc   [NUM_NEURONS];
  logic signed [PW-1:0]        prod  [NUM_NEURONS];
  logic [dataWidth-1:0]        act_y [NUM_NEURONS];
  logic signed [PW-1:0]        x_ext;

  logic [CW-1:0]               arg_idx;
  logic [CW-1:0]               best_idx;
  logic [CW-1:0]               scan_idx;
  logic signed [dataWidth-1:0] best_val;
  logic signed [dataWidth-1:0] scan_y;
  logic                        scan_better;

  logic                        beat_fire;
  logic                        last_beat;

  assign beat_fire = in_valid && (state_q == S_ACC);
  assign last_beat = (cnt == LAST_BEAT);
  assign w_addr    = cnt;
  assign out_valid = (state_q == S_OUT);

  assign x_ext = {{dataWidth{in_data[dataWidth-1]}}, in_data};

  for (genvar j = 0; j < NUM_NEURONS; j++) begin : g_neuron
    logic signed [PW-1:0]   w_ext;
    logic signed [SW-1:0]   bias_s;
    logic signed [SW-1:0]   sum_s;
    logic signed [SW-1:0]   shr_s;
    logic [dataWidth-1:0]   sat_y;

    assign w_ext   = {{dataWidth{w_data[j*dataWidth+dataWidth-1]}}, w_data[j*dataWidth +: dataWidth]};
    assign prod[j] = x_ext * w_ext;

    // Bias is aligned to the accumulator's 2*frac_bits fractional scale.
    assign bias_s = {{(SW-dataWidth){b_data[j*dataWidth+dataWidth-1]}},
                     b_data[j*dataWidth +: dataWidth]} <<< frac_bits;
    assign sum_s  = {acc[j][ACC_W-1], acc[j]} + bias_s;
    // Arithmetic shift floors toward minus infinity.
    assign shr_s  = sum_s >>> frac_bits;
    assign sat_y  = (shr_s > SAT_MAX) ? {1'b0, {(dataWidth-1){1'b1}}} :
                    (shr_s < SAT_MIN) ? {1'b1, {(dataWidth-1){1'b0}}} :
                    shr_s[dataWidth-1:0];
    assign act_y[j] = (ACT_MODE == 0 && sat_y[dataWidth-1]) ? '0 : sat_y;
  end

  // Scan reads the registered outputs; strict greater-than keeps the lowest index on ties.
  assign scan_y      = out_data[arg_idx*dataWidth +: dataWidth];
  assign scan_better = (arg_idx == '0) || (scan_y > best_val);
  assign scan_idx    = scan_better ? arg_idx : best_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_d = S_ACT;
      end
      S_ACT: state_d = (ARGMAX_EN == 1) ? S_ARG : S_OUT;
      S_ARG: if (arg_idx == LAST_NEURON) state_d = S_OUT;
      S_OUT: if (out_ready) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      out_data  <= '0;
      out_class <= '0;
      err_frame <= 1'b0;
      arg_idx   <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      for (int unsigned j = 0; j < NUM_NEURONS; j++) acc[j] <= '0;
    end else begin
      err_frame <= 1'b0;
      case (state_q)
        S_ACC: begin
          arg_idx <= '0;
          if (beat_fire) begin
            for (int unsigned j = 0; j < NUM_NEURONS; j++)
              acc[j] <= acc[j] + {{AW{prod[j][PW-1]}}, prod[j]};
            err_frame <= (in_last != last_beat);
            cnt       <= last_beat ? '0 : cnt + AW'(1);
          end
        end
        S_ACT: begin
          for (int unsigned j = 0; j < NUM_NEURONS; j++)
            out_data[j*dataWidth +: dataWidth] <= act_y[j];
          arg_idx <= '0;
        end
        S_ARG: begin
          best_idx <= scan_idx;
          if (scan_better) best_val <= scan_y;
          arg_idx <= arg_idx + CW'(1);
          if (arg_idx == LAST_NEURON) out_class <= scan_idx;
        end
        S_OUT: begin
          if (out_ready)
            for (int unsigned j = 0; j < NUM_NEURONS; j++) acc[j] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_dense_layer.sv
// Directed bench for stream_dense_layer with 4 inputs x 3 neurons, Q5.11.
// Two instances share all inputs: one ReLU, one linear.
module tb_stream_dense_layer;

  localparam int NI = 4;
  localparam int NN = 3;
  localparam int DW = 16;
  localparam int FB = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, in_last, out_ready;
  logic [DW-1:0]    in_data;
  logic [NN*DW-1:0] w_data, b_data;
  logic [3:0][NN*DW-1:0] wrom;

  logic [1:0]       w_addr_r, w_addr_l, cls_r, cls_l;
  logic             in_ready_r, in_ready_l, out_valid_r, out_valid_l, err_r, err_l;
  logic [NN*DW-1:0] out_r, out_l;

  assign w_data = wrom[w_addr_r];

  stream_dense_layer #(
    .NUM_INPUTS(NI), .NUM_NEURONS(NN), .dataWidth(DW), .frac_bits(FB),
    .ACT_MODE(0), .ARGMAX_EN(1)
  ) dut_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
    .in_data(in_data), .in_last(in_last), .w_addr(w_addr_r), .w_data(w_data),
    .b_data(b_data), .out_valid(out_valid_r), .out_ready(out_ready),
    .out_data(out_r), .out_class(cls_r), .err_frame(err_r)
  );

  stream_dense_layer #(
    .NUM_INPUTS(NI), .NUM_NEURONS(NN), .dataWidth(DW), .frac_bits(FB),
    .ACT_MODE(1), .ARGMAX_EN(1)
  ) dut_lin (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_data(in_data), .in_last(in_last), .w_addr(w_addr_l), .w_data(w_data),
    .b_data(b_data), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_data(out_l), .out_class(cls_l), .err_frame(err_l)
  );

  typedef struct {
    logic [DW-1:0]         din;
    logic [3:0][NN*DW-1:0] w;
    logic [NN*DW-1:0]      b;
    logic [NN*DW-1:0]      exp_r;
    logic [NN*DW-1:0]      exp_l;
    logic [1:0]            cls_r;
    logic [1:0]            cls_l;
  } vec_t;

  vec_t vecs [7];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [NN*DW-1:0] p3(input logic [DW-1:0] a0, a1, a2);
    return {a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic [DW-1:0] din, input logic [NN*DW-1:0] w, b, er, el,
                              input logic [1:0] cr, cl);
    vec_t v;
    v.din   = din;
    v.w     = {4{w}};
    v.b     = b;
    v.exp_r = er;
    v.exp_l = el;
    v.cls_r = cr;
    v.cls_l = cl;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i);
    wrom   = vecs[i].w;
    b_data = vecs[i].b;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last, output logic err);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    err      = err_r;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input logic [DW-1:0] d, input logic [3:0] lasts, output logic [3:0] errs);
    logic e;
    for (int i = 0; i < NI; i++) begin
      send_beat(d, lasts[i], e);
      errs[i] = e;
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid_r && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_frame(input string tag, input logic [NN*DW-1:0] er, el,
                              input logic [1:0] cr, cl);
    int lat;
    wait_out(lat);
    check({tag, "_lat"}, lat, 4);
    check({tag, "_data_relu"}, out_r, er);
    check({tag, "_data_lin"}, out_l, el);
    check({tag, "_cls_relu"}, cls_r, cr);
    check({tag, "_cls_lin"}, cls_l, cl);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_return"}, {out_valid_r, in_ready_r}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [3:0] errs;
    logic       e;
    int         lat;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    out_ready = 1'b0; wrom = '0; b_data = '0;

    vecs[0] = mk(16'h0800, p3(16'h0400, 16'h0400, 16'h0400), '0,
                 p3(16'h1000, 16'h1000, 16'h1000), p3(16'h1000, 16'h1000, 16'h1000), 2'd0, 2'd0);
    vecs[1] = mk(16'h0800, p3(16'h0400, 16'hFC00, 16'h0600), '0,
                 p3(16'h1000, 16'h0000, 16'h1800), p3(16'h1000, 16'hF000, 16'h1800), 2'd2, 2'd2);
    vecs[2] = mk(16'h7FFF, p3(16'h7FFF, 16'h7FFF, 16'h7FFF), p3(16'h7FFF, 16'h7FFF, 16'h7FFF),
                 p3(16'h7FFF, 16'h7FFF, 16'h7FFF), p3(16'h7FFF, 16'h7FFF, 16'h7FFF), 2'd0, 2'd0);
    vecs[3] = mk(16'h7FFF, p3(16'h8001, 16'h8001, 16'h8001), '0,
                 p3(16'h0000, 16'h0000, 16'h0000), p3(16'h8000, 16'h8000, 16'h8000), 2'd0, 2'd0);
    vecs[4] = mk(16'h0800, p3(16'h0200, 16'h0400, 16'h0400), '0,
                 p3(16'h0800, 16'h1000, 16'h1000), p3(16'h0800, 16'h1000, 16'h1000), 2'd1, 2'd1);
    vecs[5] = mk(16'h0001, p3(16'h0003, 16'hFFFF, 16'h0000), p3(16'h0000, 16'hFF00, 16'h0100),
                 p3(16'h0000, 16'h0000, 16'h0100), p3(16'h0000, 16'hFEFF, 16'h0100), 2'd2, 2'd2);
    vecs[6] = mk(16'h0800, '0, '0,
                 p3(16'h0A00, 16'h0100, 16'h0800), p3(16'h0A00, 16'h0100, 16'h0800), 2'd0, 2'd0);
    vecs[6].w[0] = p3(16'h0100, 16'h0100, 16'h0000);
    vecs[6].w[1] = p3(16'h0200, 16'h0000, 16'h0000);
    vecs[6].w[2] = p3(16'h0300, 16'h0000, 16'h0000);
    vecs[6].w[3] = p3(16'h0400, 16'h0000, 16'h0800);

    repeat (2) tick();
    rst = 1'b0;
    check("reset_relu", {in_ready_r, out_valid_r, err_r, w_addr_r, cls_r, out_r},
          {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 48'h0});
    check("reset_lin", {in_ready_l, out_valid_l, err_l, w_addr_l, cls_l, out_l},
          {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 48'h0});

    for (int i = 0; i < 7; i++) begin
      load(i);
      run_frame(vecs[i].din, 4'b1000, errs);
      check($sformatf("v%0d_err", i), errs, 4'b0000);
      finish_frame($sformatf("v%0d", i), vecs[i].exp_r, vecs[i].exp_l, vecs[i].cls_r, vecs[i].cls_l);
    end

    // Backpressure: result held while in_valid stays high, no beat counted.
    load(0);
    run_frame(16'h0800, 4'b1000, errs);
    wait_out(lat);
    check("bp_lat", lat, 4);
    in_valid = 1'b1; in_data = 16'h0800; in_last = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("bp_hold%0d", c), {in_ready_r, out_valid_r, w_addr_r, out_r},
            {1'b0, 1'b1, 2'b00, vecs[0].exp_r});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_return", {in_ready_r, out_valid_r, w_addr_r}, {1'b1, 1'b0, 2'b00});
    tick();
    in_valid = 1'b0;
    check("bp_first_beat", w_addr_r, 2'd1);
    send_beat(16'h0800, 1'b0, e);
    send_beat(16'h0800, 1'b0, e);
    send_beat(16'h0800, 1'b1, e);
    finish_frame("bp_frame", vecs[0].exp_r, vecs[0].exp_l, 2'd0, 2'd0);

    // Reset after two beats, asserted together with a valid beat.
    send_beat(16'h0800, 1'b0, e);
    send_beat(16'h0800, 1'b0, e);
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h0800;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_mid", {w_addr_r, in_ready_r, out_valid_r, err_r}, {2'b00, 1'b1, 1'b0, 1'b0});
    run_frame(16'h0800, 4'b1000, errs);
    finish_frame("rst_frame", vecs[0].exp_r, vecs[0].exp_l, 2'd0, 2'd0);

    // Early in_last on beat 1, then missing in_last on the final beat.
    run_frame(16'h0800, 4'b1010, errs);
    check("frm_early_err", errs, 4'b0010);
    finish_frame("frm_early", vecs[0].exp_r, vecs[0].exp_l, 2'd0, 2'd0);
    run_frame(16'h0800, 4'b0000, errs);
    check("frm_missing_err", errs, 4'b1000);
    finish_frame("frm_missing", vecs[0].exp_r, vecs[0].exp_l, 2'd0, 2'd0);
    check("err_idle", err_r, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
